// File: rtl/sd_stream_pkg.sv
// Shared definitions for the SD sector streamer: write-FSM state encoding and
// the per-sector card address step.
package sd_stream_pkg;

    typedef logic [2:0] wr_state_t;

    localparam wr_state_t ST_IDLE     = 3'd0;
    localparam wr_state_t ST_WAIT_RDY = 3'd1;
    localparam wr_state_t ST_ISSUE    = 3'd2;
    localparam wr_state_t ST_RECV     = 3'd3;
    localparam wr_state_t ST_WAIT_BUF = 3'd4;
    localparam wr_state_t ST_FINISH   = 3'd5;

    // Block-addressed cards count in sectors, byte-addressed cards in bytes.
    function automatic logic [31:0] addr_step(input int block_addr, input int sector_bytes);
        return (block_addr != 0) ? 32'd1 : 32'(sector_bytes);
    endfunction

endpackage

// File: rtl/sd_sector_buffer.sv
// Simple dual-port byte RAM holding NUM_BUFS sectors, addressed {buf_idx, byte_idx},
// with a RAM_LATENCY-stage read pipeline (last stage acts as the output register).
module sd_sector_buffer #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int RAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem  [DEPTH];
    logic [7:0] r_pipe [RAM_LATENCY];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_pipe[0] <= r_mem[i_raddr];
        for (int i = 1; i < RAM_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_rdata = r_pipe[RAM_LATENCY-1];

endmodule

// File: rtl/sd_sector_streamer.sv
// Reads a run of consecutive SD sectors into a ring of sector buffers and
// streams the bytes in order over a valid/ready byte interface.
module sd_sector_streamer
    import sd_stream_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int NUM_BUFS     = 2,
    parameter int BLOCK_ADDR   = 0,
    parameter int RAM_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic [31:0] start_addr_in,
    input  logic [31:0] num_sectors_in,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [7:0]  axiod,
    output logic        axiov,
    input  logic        axiir,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] sectors_done_out,
    output logic        overflow_out,
    output logic [2:0]  o_dbg_state
);

    localparam int BYTE_W = $clog2(SECTOR_BYTES);
    localparam int BUF_W  = $clog2(NUM_BUFS);
    localparam int ADDR_W = BUF_W + BYTE_W;
    localparam int CAP    = RAM_LATENCY + 1;
    localparam int PTR_W  = $clog2(CAP);
    localparam int CNT_W  = $clog2(CAP + 1);
    localparam logic [31:0] ADDR_STEP = addr_step(BLOCK_ADDR, SECTOR_BYTES);

    // Write side
    wr_state_t            r_state;
    logic                 r_prev_avail;
    logic [31:0]          r_addr;
    logic [31:0]          r_remain;
    logic [BUF_W-1:0]     r_wr_buf;
    logic [BYTE_W-1:0]    r_wr_cnt;
    logic [NUM_BUFS-1:0]  r_full;
    logic                 r_sd_rd;
    logic [31:0]          r_sd_addr;
    logic                 r_busy;
    logic                 r_done;
    logic [31:0]          r_sectors;
    logic                 r_overflow;

    // Read side
    logic [BUF_W-1:0]     r_fetch_buf;
    logic [BYTE_W-1:0]    r_fetch_cnt;
    logic [BUF_W-1:0]     r_xfer_buf;
    logic [BYTE_W-1:0]    r_xfer_cnt;
    logic [RAM_LATENCY-1:0] r_vld;
    logic [CNT_W-1:0]     r_inflight;
    logic [7:0]           r_fifo [CAP];
    logic [PTR_W-1:0]     r_fifo_rp;
    logic [PTR_W-1:0]     r_fifo_wp;
    logic [CNT_W-1:0]     r_fifo_cnt;

    logic                 w_byte_stb;
    logic                 w_wr_en;
    logic                 w_sector_end;
    logic                 w_pop;
    logic                 w_last_xfer;
    logic                 w_fetch;
    logic                 w_arrive;
    logic [7:0]           w_ram_rdata;
    logic [NUM_BUFS-1:0]  w_set_mask;
    logic [NUM_BUFS-1:0]  w_clr_mask;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CAP - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_byte_stb   = sd_byte_available && !r_prev_avail;
    assign w_wr_en      = w_byte_stb && (r_state == ST_RECV);
    assign w_sector_end = w_wr_en && (r_wr_cnt == BYTE_W'(SECTOR_BYTES - 1));

    // axiov/axiir: a byte moves on every cycle where both are high; once axiov
    // rises, axiov and axiod hold unchanged until that transfer cycle.
    assign axiov       = (r_fifo_cnt != '0);
    assign axiod       = r_fifo[r_fifo_rp];
    assign w_pop       = axiov && axiir;
    assign w_last_xfer = w_pop && (r_xfer_cnt == BYTE_W'(SECTOR_BYTES - 1));
    assign w_arrive    = r_vld[RAM_LATENCY-1];

    // Fetch only with room reserved for every byte already in the RAM pipeline.
    assign w_fetch = r_full[r_fetch_buf] &&
                     ((int'(r_fifo_cnt) + int'(r_inflight)) < (CAP + int'(w_pop)));

    assign w_set_mask = w_sector_end ? (NUM_BUFS'(1) << r_wr_buf) : '0;
    assign w_clr_mask = w_last_xfer ? (NUM_BUFS'(1) << r_xfer_buf) : '0;

    sd_sector_buffer #(
        .DEPTH       (NUM_BUFS * SECTOR_BYTES),
        .ADDR_W      (ADDR_W),
        .RAM_LATENCY (RAM_LATENCY)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr ({r_wr_buf, r_wr_cnt}),
        .i_wdata (sd_dout),
        .i_raddr ({r_fetch_buf, r_fetch_cnt}),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_prev_avail <= 1'b0;
            r_addr       <= '0;
            r_remain     <= '0;
            r_wr_buf     <= '0;
            r_wr_cnt     <= '0;
            r_full       <= '0;
            r_sd_rd      <= 1'b0;
            r_sd_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sectors    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_avail <= sd_byte_available;
            r_done       <= 1'b0;
            r_full       <= (r_full | w_set_mask) & ~w_clr_mask;
            if (w_byte_stb && (r_state != ST_RECV)) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        if (num_sectors_in != '0) begin
                            r_addr    <= start_addr_in;
                            r_remain  <= num_sectors_in;
                            r_sectors <= '0;
                            r_wr_cnt  <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_WAIT_BUF;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_WAIT_BUF: begin
                    if (!r_full[r_wr_buf]) begin
                        r_state <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (sd_ready) begin
                        r_sd_rd   <= 1'b1;
                        r_sd_addr <= r_addr;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!sd_ready) begin
                        r_sd_rd <= 1'b0;
                        r_state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (w_wr_en) begin
                        r_wr_cnt <= r_wr_cnt + BYTE_W'(1);
                        if (w_sector_end) begin
                            r_wr_buf  <= r_wr_buf + BUF_W'(1);
                            r_addr    <= r_addr + ADDR_STEP;
                            r_sectors <= r_sectors + 32'd1;
                            r_remain  <= r_remain - 32'd1;
                            r_state   <= (r_remain == 32'd1) ? ST_FINISH : ST_WAIT_BUF;
                        end
                    end
                end
                ST_FINISH: begin
                    if ((r_full == '0) && !axiov) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_buf <= '0;
            r_fetch_cnt <= '0;
            r_xfer_buf  <= '0;
            r_xfer_cnt  <= '0;
            r_vld       <= '0;
            r_inflight  <= '0;
            r_fifo_rp   <= '0;
            r_fifo_wp   <= '0;
            r_fifo_cnt  <= '0;
            for (int i = 0; i < CAP; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + BYTE_W'(1);
                if (r_fetch_cnt == BYTE_W'(SECTOR_BYTES - 1)) begin
                    r_fetch_buf <= r_fetch_buf + BUF_W'(1);
                end
            end
            r_vld[0] <= w_fetch;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_inflight <= r_inflight + CNT_W'(w_fetch) - CNT_W'(w_arrive);
            if (w_arrive) begin
                r_fifo[r_fifo_wp] <= w_ram_rdata;
                r_fifo_wp         <= ptr_next(r_fifo_wp);
            end
            if (w_pop) begin
                r_fifo_rp  <= ptr_next(r_fifo_rp);
                r_xfer_cnt <= r_xfer_cnt + BYTE_W'(1);
                if (w_last_xfer) begin
                    r_xfer_buf <= r_xfer_buf + BUF_W'(1);
                end
            end
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_arrive) - CNT_W'(w_pop);
        end
    end

    assign sd_rd            = r_sd_rd;
    assign sd_addr          = r_sd_addr;
    assign busy_out         = r_busy;
    assign done_out         = r_done;
    assign sectors_done_out = r_sectors;
    assign overflow_out     = r_overflow;
    assign o_dbg_state      = r_state;

endmodule

// File: doc/sd_sector_streamer.md
Name: sd_sector_streamer

Overview:
- Reads a run of consecutive SD sectors through the existing sd_controller byte interface.
- Buffers each sector in a ping-pong (NUM_BUFS-deep) sector RAM.
- Streams the bytes in order to the MP3 front end (header_finder/plexer) over a valid/ready byte stream with downstream backpressure.
- Supersedes the single-sector, fixed-address, no-backpressure capture in the current top level.

Parameters:
- SECTOR_BYTES, 512, bytes per sector; power of two.
- NUM_BUFS, 2, sector buffers in the ring; power of two, 2..8.
- BLOCK_ADDR, 0, 0 = byte-addressed card (address step SECTOR_BYTES); 1 = block-addressed card (address step 1).
- RAM_LATENCY, 2, sector RAM read latency in cycles (2 = HIGH_PERFORMANCE output register).

Ports:
- clk  in  1  system clock; sd_controller handshake signals are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  one-cycle pulse that begins a run; ignored while busy_out=1.
- start_addr_in  in  32  first sector address, sampled on start_in.
- num_sectors_in  in  32  sectors to read, sampled on start_in; 0 = no read.
- sd_ready  in  1  sd_controller ready.
- sd_rd  out  1  read request to sd_controller.
- sd_addr  out  32  read address to sd_controller.
- sd_dout  in  8  byte from sd_controller.
- sd_byte_available  in  1  level from sd_controller; each rising edge marks one byte.
- axiod  out  8  output byte.
- axiov  out  1  output byte valid.
- axiir  in  1  downstream ready; a transfer occurs on axiov&&axiir.
- busy_out  out  1  high from an accepted start until done.
- done_out  out  1  one-cycle pulse after the last byte of the run is transferred.
- sectors_done_out  out  32  count of sectors fully received from the card.
- overflow_out  out  1  sticky error flag; see boundaries.

Behaviour:
- Reset values: sd_rd=0, sd_addr=0, axiod=0, axiov=0, busy_out=0, done_out=0, sectors_done_out=0, overflow_out=0. Reset also clears every buffer-full flag and all pointers and counters, and returns the FSM to IDLE. Reset mid-read drops sd_rd in the same cycle it is applied; a partial sector is discarded.
- Byte strobe: byte_stb = sd_byte_available && !prev_avail, with prev_avail registered every cycle.
- Write FSM states: IDLE, WAIT_RDY, ISSUE, RECV, WAIT_BUF, FINISH.
  - IDLE: start_in with num_sectors_in>0 latches the address and count, sets busy_out -> WAIT_BUF.
  - IDLE: start_in with num_sectors_in=0 pulses done_out the next cycle, busy_out stays 0.
  - WAIT_BUF: proceeds -> WAIT_RDY when the write buffer's full flag is 0.
  - WAIT_RDY: proceeds -> ISSUE when sd_ready=1.
  - ISSUE: holds sd_rd=1 and sd_addr=current address until sd_ready falls, then sd_rd=0 -> RECV.
  - RECV: each byte_stb writes sd_dout to buf[wr_buf][wr_cnt] and increments wr_cnt.
  - RECV, on the strobe where wr_cnt reaches SECTOR_BYTES-1: set full[wr_buf]; advance wr_buf (mod NUM_BUFS); add the address step (BLOCK_ADDR ? 1 : SECTOR_BYTES); increment sectors_done_out; decrement the remaining count. Remaining=0 -> FINISH, else -> WAIT_BUF.
  - FINISH: waits until every full flag is clear and the output holds no valid byte, pulses done_out, clears busy_out -> IDLE.
- Read side runs concurrently with the write FSM.
  - When full[rd_buf]=1, bytes are fetched in order into a RAM_LATENCY-deep skid so that axiov can sustain one byte per cycle while axiir=1.
  - axiod and axiov hold stable while axiov&&!axiir.
  - After the last byte of a buffer transfers: clear full[rd_buf], advance rd_buf.
  - Simultaneous set and clear of different buffers in one cycle are both honoured.
- Latency: the first byte is valid no earlier than RAM_LATENCY+1 cycles after the sector's final byte_stb. A sector is never streamed before it is complete.
- Boundaries:
  - byte_stb outside RECV: byte dropped, overflow_out=1.
  - All buffers full: the FSM stalls in WAIT_BUF with no sd_rd issued, so no card data is lost.
  - Address wraps modulo 2^32.
  - start_in while busy: no effect.

Decomposition:
- Package sd_stream_pkg: write-FSM state enum, and a localparam function computing the address step from BLOCK_ADDR and SECTOR_BYTES.
- Sub-module sd_sector_buffer: simple dual-port BRAM of NUM_BUFS*SECTOR_BYTES x 8, addressed {buf_idx, byte_idx}, with parametrised RAM_LATENCY output register.
- Full flags, FSM and skid logic stay in sd_sector_streamer.

Test Plan:
- start_addr=0, num=1, BLOCK_ADDR=0, axiir=1, card model returns bytes i%256 -> one sd_rd at addr 0; 512 transfers of 0..255,0..255; done_out pulses once; sectors_done_out=1.
- num=3, BLOCK_ADDR=0, start_addr=512 -> sd_rd at 512, 1024, 1536; 1536 bytes out in order.
- Same with BLOCK_ADDR=1, start_addr=7 -> addresses 7, 8, 9.
- num=4, NUM_BUFS=2, axiir=0 -> exactly 2 sd_rd issued, then stall in WAIT_BUF. Raise axiir -> remaining 2 sectors read, 2048 bytes out, no overflow.
- Random axiir toggling at 30% duty -> output equals the card stream with no duplicates or gaps; axiod stable while stalled.
- Assert rst during sector 2 RECV -> next cycle sd_rd=0, axiov=0, busy_out=0. A new start then reads cleanly.
- Extra byte_stb injected while in WAIT_RDY -> overflow_out=1 and stays 1 until rst.
